instr_sequencer: RTL and testbench

Multi-cycle control FSM that steps the accumulator CPU through fetch, decode, execute, memory and writeback for every instruction. It sits between the opcode decoder and the datapath, handshakes with instruction/data memory and the multi-cycle ALU, and produces one-cycle strobes for PC, IR, accumulator and flags. Illegal opcodes trap it into a sticky fault state.

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/branch_cond.sv | 29 ++
 rtl/instr_sequencer.sv | 167 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode map, opcode-class ranges and sequencer state encodings
// for the accumulator CPU control path.
package cpu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_LOAD  = 6'h00;
    localparam logic [OP_W-1:0] OP_STORE = 6'h01;
    localparam logic [OP_W-1:0] OP_BRZ   = 6'h02;
    localparam logic [OP_W-1:0] OP_BRN   = 6'h03;
    localparam logic [OP_W-1:0] OP_BRC   = 6'h04;
    localparam logic [OP_W-1:0] OP_BRO   = 6'h05;
    localparam logic [OP_W-1:0] OP_BRA   = 6'h06;
    localparam logic [OP_W-1:0] OP_JMP   = 6'h07;
    localparam logic [OP_W-1:0] OP_RET   = 6'h08;
    localparam logic [OP_W-1:0] OP_ADD   = 6'h09;
    localparam logic [OP_W-1:0] OP_SUB   = 6'h0A;
    localparam logic [OP_W-1:0] OP_AND   = 6'h0B;
    localparam logic [OP_W-1:0] OP_OR    = 6'h0C;
    localparam logic [OP_W-1:0] OP_XOR   = 6'h0D;
    localparam logic [OP_W-1:0] OP_NOT   = 6'h0E;
    localparam logic [OP_W-1:0] OP_MOV   = 6'h0F;
    localparam logic [OP_W-1:0] OP_MUL   = 6'h10;
    localparam logic [OP_W-1:0] OP_DIV   = 6'h11;
    localparam logic [OP_W-1:0] OP_MOD   = 6'h12;
    localparam logic [OP_W-1:0] OP_SHL   = 6'h13;
    localparam logic [OP_W-1:0] OP_SHR   = 6'h14;
    localparam logic [OP_W-1:0] OP_ADC   = 6'h15;
    localparam logic [OP_W-1:0] OP_SBC   = 6'h16;
    localparam logic [OP_W-1:0] OP_CMP   = 6'h17;
    localparam logic [OP_W-1:0] OP_TST   = 6'h18;
    localparam logic [OP_W-1:0] OP_INC   = 6'h19;
    localparam logic [OP_W-1:0] OP_DEC   = 6'h1A;

    localparam logic [OP_W-1:0] BR_FIRST  = OP_BRZ;
    localparam logic [OP_W-1:0] BR_LAST   = OP_RET;
    localparam logic [OP_W-1:0] ALU_FIRST = OP_ADD;
    localparam logic [OP_W-1:0] ALU_LAST  = OP_DEC;
    localparam logic [OP_W-1:0] MC_FIRST  = OP_MUL;
    localparam logic [OP_W-1:0] MC_LAST   = OP_MOD;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_DECODE = 3'd2;
    localparam state_t S_EXEC   = 3'd3;
    localparam state_t S_MEM    = 3'd4;
    localparam state_t S_WB     = 3'd5;
    localparam state_t S_BRANCH = 3'd6;
    localparam state_t S_FAULT  = 3'd7;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-taken evaluation for the conditional branch,
// unconditional branch, jmp and ret opcodes.
module branch_cond #(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_z,
    input  logic                flag_n,
    input  logic                flag_c,
    input  logic                flag_v,
    output logic                taken
);
    import cpu_pkg::*;

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OPCODE_W'(OP_BRZ): taken = flag_z;
            OPCODE_W'(OP_BRN): taken = flag_n;
            OPCODE_W'(OP_BRC): taken = flag_c;
            OPCODE_W'(OP_BRO): taken = flag_v;
            OPCODE_W'(OP_BRA),
            OPCODE_W'(OP_JMP),
            OPCODE_W'(OP_RET): taken = 1'b1;
            default:           taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM.
// Optional memory-request watchdog: define INSTR_SEQ_MEM_TIMEOUT_EN.
module instr_sequencer #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_z,
    input  logic                flag_n,
    input  logic                flag_c,
    input  logic                flag_v,
    input  logic                mem_ack,
    input  logic                alu_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_sel,
    output logic                ir_ld,
    output logic                alu_start,
    output logic                acc_ld,
    output logic                flags_ld,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                stk_push,
    output logic                stk_pop,
    output logic                instr_done,
    output logic                fault,
    output logic [2:0]          state_o
);
    import cpu_pkg::*;

    state_t state;
    state_t state_nx;
    logic   exec_wait;
    logic   taken;
    logic   timeout;

    logic is_store, is_mem, is_branch, is_alu, is_multi;
    logic is_jmp, is_ret, no_acc, no_flags;

    assign is_store  = (opcode == OPCODE_W'(OP_STORE));
    assign is_mem    = (opcode == OPCODE_W'(OP_LOAD)) || is_store;
    assign is_branch = (opcode >= OPCODE_W'(BR_FIRST)) && (opcode <= OPCODE_W'(BR_LAST));
    assign is_alu    = (opcode >= OPCODE_W'(ALU_FIRST)) && (opcode <= OPCODE_W'(ALU_LAST));
    assign is_multi  = (opcode >= OPCODE_W'(MC_FIRST)) && (opcode <= OPCODE_W'(MC_LAST));
    assign is_jmp    = (opcode == OPCODE_W'(OP_JMP));
    assign is_ret    = (opcode == OPCODE_W'(OP_RET));
    assign no_acc    = (opcode == OPCODE_W'(OP_CMP)) || (opcode == OPCODE_W'(OP_TST));
    assign no_flags  = (opcode == OPCODE_W'(OP_MOV)) || is_mem;

    branch_cond #(.OPCODE_W(OPCODE_W)) u_branch_cond (
        .opcode (opcode),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .taken  (taken)
    );

`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state_nx != state)
            wait_cnt <= '0;
        else if (mem_req && !mem_ack)
            wait_cnt <= wait_cnt + TW'(1);
    end

    // Fires on the MEM_TIMEOUT-th consecutive unacknowledged request cycle.
    assign timeout = mem_req && !mem_ack && (wait_cnt == TW'(MEM_TIMEOUT - 1));
`else
    // Without the watchdog a request waits for its ack indefinitely.
    assign timeout = (MEM_TIMEOUT < 0);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (run) state_nx = S_FETCH;
            S_FETCH: begin
                if (mem_ack)      state_nx = S_DECODE;
                else if (timeout) state_nx = S_FAULT;
            end
            S_DECODE: begin
                if (is_mem)         state_nx = S_MEM;
                else if (is_branch) state_nx = S_BRANCH;
                else if (is_alu)    state_nx = S_EXEC;
                else                state_nx = S_FAULT;
            end
            S_EXEC: begin
                if (!is_multi || (exec_wait && alu_done)) state_nx = S_WB;
            end
            S_MEM: begin
                if (mem_ack)      state_nx = is_store ? (run ? S_FETCH : S_IDLE) : S_WB;
                else if (timeout) state_nx = S_FAULT;
            end
            S_WB, S_BRANCH: state_nx = run ? S_FETCH : S_IDLE;
            S_FAULT:  state_nx = S_FAULT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            exec_wait <= 1'b0;
        end else begin
            state     <= state_nx;
            // Marks EXEC cycles after the first, so alu_start is a single pulse
            // and alu_done is only honoured once the ALU has been started.
            exec_wait <= (state == S_EXEC) && (state_nx == S_EXEC);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_ld      = 1'b0;
        alu_start  = 1'b0;
        acc_ld     = 1'b0;
        flags_ld   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_ld   = mem_ack;
            end
            S_EXEC: alu_start = !exec_wait;
            S_MEM: begin
                mem_req    = 1'b1;
                mem_sel    = 1'b1;
                mem_we     = is_store;
                pc_inc     = mem_ack && is_store;
                instr_done = mem_ack && is_store;
            end
            S_WB: begin
                acc_ld     = !no_acc;
                flags_ld   = !no_flags;
                pc_inc     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                pc_load    = taken;
                pc_inc     = !taken;
                stk_push   = is_jmp;
                stk_pop    = is_ret;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault   = (state == S_FAULT);
    assign state_o = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed and random instructions
// compared cycle by cycle against an instruction-level expected strobe trace.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [5:0] opcode = '0;
    logic       flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0, flag_v = 1'b0;
    logic       mem_ack = 1'b0, alu_done = 1'b0;
    logic       mem_req, mem_we, mem_sel, ir_ld, alu_start, acc_ld, flags_ld;
    logic       pc_inc, pc_load, stk_push, stk_pop, instr_done, fault;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    bit parked;

    localparam logic [12:0] M_REQ  = 13'h1000, M_WE   = 13'h0800, M_SEL  = 13'h0400;
    localparam logic [12:0] M_IR   = 13'h0200, M_AS   = 13'h0100, M_ACC  = 13'h0080;
    localparam logic [12:0] M_FLG  = 13'h0040, M_INC  = 13'h0020, M_LD   = 13'h0010;
    localparam logic [12:0] M_PUSH = 13'h0008, M_POP  = 13'h0004, M_DONE = 13'h0002;
    localparam logic [12:0] M_FLT  = 13'h0001;

    instr_sequencer #(.OPCODE_W(6), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .mem_ack(mem_ack), .alu_done(alu_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_ld(ir_ld),
        .alu_start(alu_start), .acc_ld(acc_ld), .flags_ld(flags_ld),
        .pc_inc(pc_inc), .pc_load(pc_load), .stk_push(stk_push), .stk_pop(stk_pop),
        .instr_done(instr_done), .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] observed();
        return {mem_req, mem_we, mem_sel, ir_ld, alu_start, acc_ld, flags_ld,
                pc_inc, pc_load, stk_push, stk_pop, instr_done, fault};
    endfunction

    task automatic check_vec(input string tag, input logic [12:0] exp);
        checks++;
        assert (observed() === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed(), exp);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        assert (state_o === 3'd0) else begin
            errors++;
            $error("FAIL %s state_o observed=%0d expected=0", tag, state_o);
        end
    endtask

    // One clock: drive qualifiers, compare at the falling edge, advance.
    task automatic step(input string tag, input logic [12:0] exp,
                        input logic ack, input logic done, input bit idle);
        mem_ack  = ack;
        alu_done = done;
        @(negedge clk);
        check_vec(tag, exp);
        if (idle) check_idle(tag);
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        alu_done = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        run = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_vec(tag, '0);
        check_idle(tag);
        @(posedge clk);
        #1 rst = 1'b0;
        parked = 1'b1;
    endtask

    // Expected strobe trace derived from the instruction's class and the
    // handshake delays chosen for it.
    task automatic run_instr(input logic [5:0] op, input logic [3:0] flags,
                             input int fwait, input int mwait, input int lat,
                             input bit run_after);
        bit st, ls, br, alu, multi, taken;
        logic [12:0] exp;
        opcode = op;
        {flag_z, flag_n, flag_c, flag_v} = flags;
        st    = (op == 6'h01);
        ls    = (op <= 6'h01);
        br    = (op >= 6'h02) && (op <= 6'h08);
        alu   = (op >= 6'h09) && (op <= 6'h1A);
        multi = (op >= 6'h10) && (op <= 6'h12);
        case (op)
            6'h02:   taken = flags[3];
            6'h03:   taken = flags[2];
            6'h04:   taken = flags[1];
            6'h05:   taken = flags[0];
            default: taken = 1'b1;
        endcase
        if (parked) begin
            run = 1'b1;
            step("idle_exit", '0, 1'b1, 1'b0, 1'b1);
        end
        run = run_after;
        for (int i = 0; i < fwait; i++) step("fetch_wait", M_REQ, 1'b0, 1'b0, 1'b0);
        step("fetch_ack", M_REQ | M_IR, 1'b1, 1'b0, 1'b0);
        step("decode", '0, 1'b1, 1'b1, 1'b0);
        if (!(ls || br || alu)) begin
            for (int i = 0; i < 4; i++) begin
                run = (i % 2 == 0);
                step("fault_hold", M_FLT, 1'b1, 1'b0, 1'b0);
            end
            return;
        end
        if (ls) begin
            exp = M_REQ | M_SEL | (st ? M_WE : 13'h0);
            for (int i = 0; i < mwait; i++) step("mem_wait", exp, 1'b0, 1'b0, 1'b0);
            step("mem_ack", exp | (st ? (M_INC | M_DONE) : 13'h0), 1'b1, 1'b0, 1'b0);
            if (!st) step("wb_load", M_ACC | M_INC | M_DONE, 1'b0, 1'b0, 1'b0);
        end else if (br) begin
            exp = M_DONE | (taken ? M_LD : M_INC);
            if (op == 6'h07) exp |= M_PUSH;
            if (op == 6'h08) exp |= M_POP;
            step("branch", exp, 1'b0, 1'b0, 1'b0);
        end else begin
            if (multi) begin
                step("exec_start", M_AS, 1'b0, 1'b1, 1'b0);
                for (int i = 2; i < lat; i++) step("exec_wait", '0, 1'b0, 1'b0, 1'b0);
                step("exec_done", '0, 1'b0, 1'b1, 1'b0);
            end else begin
                step("exec", M_AS, 1'b0, 1'b0, 1'b0);
            end
            exp = M_INC | M_DONE;
            if (op != 6'h17 && op != 6'h18) exp |= M_ACC;
            if (op != 6'h0F) exp |= M_FLG;
            step("wb_alu", exp, 1'b0, 1'b0, 1'b0);
        end
        parked = !run_after;
        if (parked) step("idle_park", '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2;
        check_vec("reset_outputs", '0);
        check_idle("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;
        parked = 1'b1;

        run_instr(6'h09, 4'h0, 0, 0, 0, 1'b1);
        run_instr(6'h10, 4'h0, 0, 0, 5, 1'b1);
        run_instr(6'h02, 4'b1000, 0, 0, 0, 1'b1);
        run_instr(6'h02, 4'b0111, 0, 0, 0, 1'b1);
        run_instr(6'h07, 4'h0, 1, 0, 0, 1'b1);
        run_instr(6'h08, 4'h0, 0, 0, 0, 1'b1);
        run_instr(6'h01, 4'h0, 0, 3, 0, 1'b1);
        run_instr(6'h00, 4'h0, 2, 1, 0, 1'b0);
        run_instr(6'h0F, 4'h0, 0, 0, 0, 1'b1);
        run_instr(6'h17, 4'h0, 0, 0, 0, 1'b1);
        run_instr(6'h18, 4'h0, 0, 0, 0, 1'b0);
        run_instr(6'h12, 4'h0, 0, 0, 2, 1'b1);

        for (int n = 0; n < 60; n++) begin
            run_instr(6'($urandom_range(0, 26)), 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(2, 6)), $urandom_range(0, 3) != 0);
        end

        // Reset while a load waits on memory.
        opcode = 6'h00;
        if (parked) begin
            run = 1'b1;
            step("idle_exit", '0, 1'b0, 1'b0, 1'b1);
        end
        step("fetch_ack", M_REQ | M_IR, 1'b1, 1'b0, 1'b0);
        step("decode", '0, 1'b0, 1'b0, 1'b0);
        step("mem_wait", M_REQ | M_SEL, 1'b0, 1'b0, 1'b0);
        do_reset("async_reset_mid");
        run_instr(6'h0A, 4'h0, 0, 0, 0, 1'b1);

        run_instr(6'h3F, 4'h0, 0, 0, 0, 1'b1);
        do_reset("reset_from_fault");
        run_instr(6'h1B, 4'h0, 1, 0, 0, 1'b1);
        do_reset("reset_from_fault2");
        run_instr(6'h19, 4'h0, 0, 0, 0, 1'b0);

`ifdef INSTR_SEQ_MEM_TIMEOUT_EN
        run = 1'b1;
        if (parked) step("idle_exit", '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step("timeout_wait", M_REQ, 1'b0, 1'b0, 1'b0);
        step("timeout_fault", M_FLT, 1'b0, 1'b0, 1'b0);
        do_reset("reset_from_timeout");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
